// File: rtl/reg_port_arb.sv
// reg_port_arb: round-robin arbiter sharing one local register-access port
// (cs/we/addr/data, rdata back) between NUM_REQ requesters. Each access is
// sequenced through a fixed-latency protocol: IDLE -> ACCESS (-> RD_WAIT ->
// RD_DONE for reads) -> IDLE.
// Optional feature: define REG_PORT_ARB_PRIO0_EN to give requester 0 absolute
// priority; the remaining requesters keep sharing round-robin.
module reg_port_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                      i_pclk,
  input  logic                      i_presetn,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_busy,
  output logic                      o_cs,
  output logic                      o_we,
  output logic [ADDR_W-1:0]         o_addr,
  output logic [DATA_W-1:0]         o_data,
  input  logic [DATA_W-1:0]         i_data
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = ID_W + 1;
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_nxt;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  pick_id;
  logic             pick_vld;
  logic             cmd_we;
  logic [LAT_W-1:0] lat_cnt;

  // Winner search: first requesting index starting at ptr, wrapping mod NUM_REQ.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [ID_W-1:0]  idx;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pick_id  = '0;
    pick_vld = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!pick_vld && i_req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
`ifdef REG_PORT_ARB_PRIO0_EN
    if (i_req[0]) pick_id = '0;
`endif
  end

  // Pointer advance: the index just after the current winner, wrapping to 0.
  always_comb begin
    ptr_nxt = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
  end

  // State register.
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) state <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    else            state <= state_nxt;
  end

  // Command latch, round-robin pointer, read-latency counter and read data.
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      ptr     <= '0;
      win_id  <= '0;
      cmd_we  <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
      lat_cnt <= '0;
      o_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // o_addr/o_data double as the latched command, so they only move
          // when a new access is accepted and hold otherwise.
          if (pick_vld) begin
            win_id <= pick_id;
            cmd_we <= i_we[pick_id];
            o_addr <= i_addr[pick_id*ADDR_W +: ADDR_W];
            o_data <= i_wdata[pick_id*DATA_W +: DATA_W];
          end
        end
        S_ACCESS: begin
`ifdef REG_PORT_ARB_PRIO0_EN
          // A requester-0 grant leaves the shared rotation untouched.
          if (win_id != '0) ptr <= ptr_nxt;
`else
          ptr <= ptr_nxt;
`endif
          lat_cnt <= LAT_W'(RD_LAT - 1);
        end
        S_RD_WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
          else               o_rdata <= i_data;
        end
        default: ;
      endcase
    end
  end

  // Next-state and port/handshake outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    o_cs      = 1'b0;
    o_we      = 1'b0;
    o_gnt     = '0;
    o_rvalid  = '0;
    o_busy    = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (pick_vld) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        o_cs          = 1'b1;
        o_we          = cmd_we;
        o_gnt[win_id] = 1'b1;
        state_nxt     = cmd_we ? S_IDLE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_cnt == '0) state_nxt = S_RD_DONE;
      end
      S_RD_DONE: begin
        o_rvalid[win_id] = 1'b1;
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_port_arb.sv
// tb_reg_port_arb: scoreboard bench for reg_port_arb (NUM_REQ=3, RD_LAT=2).
// Requester agents replay per-requester command queues; the test pushes the
// hand-computed expected port accesses and read completions; a negedge
// monitor pops and compares whenever o_cs or o_rvalid is seen.
// Expectations follow REG_PORT_ARB_PRIO0_EN when it is defined.
module tb_reg_port_arb;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int RD_LAT  = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ-1:0]        i_we;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ*DATA_W-1:0] i_wdata;
  logic [NUM_REQ-1:0]        o_gnt;
  logic [NUM_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]         o_rdata;
  logic                      o_busy;
  logic                      o_cs;
  logic                      o_we;
  logic [ADDR_W-1:0]         o_addr;
  logic [DATA_W-1:0]         o_data;
  logic [DATA_W-1:0]         i_data;

  reg_port_arb #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .i_pclk   (clk),
    .i_presetn(rst_n),
    .i_req    (i_req),
    .i_we     (i_we),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .o_gnt    (o_gnt),
    .o_rvalid (o_rvalid),
    .o_rdata  (o_rdata),
    .o_busy   (o_busy),
    .o_cs     (o_cs),
    .o_we     (o_we),
    .o_addr   (o_addr),
    .o_data   (o_data),
    .i_data   (i_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } acc_t;

  typedef struct {
    logic [NUM_REQ-1:0] rv;
    logic [DATA_W-1:0]  data;
  } rd_t;

  cmd_t cmd_q [NUM_REQ][$];
  acc_t acc_q[$];
  rd_t  rd_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_cs_cyc = -100;
  logic prev_cs = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register-file model behind the port: read data is a fixed function of address.
  function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
    return 32'h1234_5658 + a;
  endfunction

  task automatic issue(input int r, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    cmd_q[r].push_back(c);
  endtask

  task automatic exp_acc(input logic [NUM_REQ-1:0] g, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    acc_t e;
    e.gnt = g; e.we = we; e.addr = a; e.data = d;
    acc_q.push_back(e);
  endtask

  task automatic exp_rd(input logic [NUM_REQ-1:0] rv, input logic [DATA_W-1:0] d);
    rd_t e;
    e.rv = rv; e.data = d;
    rd_q.push_back(e);
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester agents and register-port read-data driver.
  initial begin : agents
    logic              cs_hist   [0:4];
    logic [ADDR_W-1:0] addr_hist [0:4];
    logic [NUM_REQ-1:0]        req_v, we_v;
    logic [NUM_REQ*ADDR_W-1:0] addr_v;
    logic [NUM_REQ*DATA_W-1:0] wdata_v;
    for (int k = 0; k < 5; k++) begin
      cs_hist[k] = 1'b0;
      addr_hist[k] = '0;
    end
    i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0; i_data = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (o_gnt[r] && cmd_q[r].size() > 0) void'(cmd_q[r].pop_front());
        if (cmd_q[r].size() > 0) begin
          req_v[r] = 1'b1;
          we_v[r]  = cmd_q[r][0].we;
          addr_v[r*ADDR_W +: ADDR_W]  = cmd_q[r][0].addr;
          wdata_v[r*DATA_W +: DATA_W] = cmd_q[r][0].wdata;
        end
      end
      i_req = req_v; i_we = we_v; i_addr = addr_v; i_wdata = wdata_v;
      for (int k = 4; k > 0; k--) begin
        cs_hist[k]   = cs_hist[k-1];
        addr_hist[k] = addr_hist[k-1];
      end
      cs_hist[0]   = o_cs;
      addr_hist[0] = o_addr;
      // Valid only in the capture cycle, garbage otherwise.
      i_data = cs_hist[RD_LAT] ? rd_model(addr_hist[RD_LAT]) : 32'hDEAD_BEEF;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an access or a completion.
  initial forever begin
    acc_t ea;
    rd_t  er;
    @(negedge clk);
    if (o_cs) begin
      check("cs_back_to_back", {63'd0, prev_cs}, 64'd0);
      if (acc_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_access: gnt=%b addr=0x%0h, want none (cycle %0d)", o_gnt, o_addr, cyc);
      end else begin
        ea = acc_q.pop_front();
        check("acc_gnt",  {61'd0, o_gnt}, {61'd0, ea.gnt});
        check("acc_we",   {63'd0, o_we},  {63'd0, ea.we});
        check("acc_addr", {32'd0, o_addr}, {32'd0, ea.addr});
        check("acc_data", {32'd0, o_data}, {32'd0, ea.data});
      end
      last_cs_cyc = cyc;
    end else if (o_gnt != '0) begin
      n_cmp++; n_err++;
      $display("FAIL gnt_without_cs: got gnt=%b, want 000 (cycle %0d)", o_gnt, cyc);
    end
    if (o_rvalid != '0) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_rvalid: got rvalid=%b, want none (cycle %0d)", o_rvalid, cyc);
      end else begin
        er = rd_q.pop_front();
        check("rd_rvalid",  {61'd0, o_rvalid}, {61'd0, er.rv});
        check("rd_rdata",   {32'd0, o_rdata},  {32'd0, er.data});
        check("rd_latency", 64'(cyc - last_cs_cyc), 64'(RD_LAT + 1));
      end
    end
    prev_cs = o_cs;
  end

  // Count negedges from now until o_cs is seen; compare to the expected count.
  task automatic wait_cs(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_cs && n < 20);
    check(name, 64'(n), 64'(exp_n));
  endtask

  task automatic wait_rv(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_rvalid == '0 && n < 20);
    check(name, 64'(n), 64'(exp_n));
  endtask

  // Wait until all commands are granted, the scoreboard is drained and the DUT is idle.
  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (cmd_q[0].size() == 0) && (cmd_q[1].size() == 0) && (cmd_q[2].size() == 0) &&
             (acc_q.size() == 0) && (rd_q.size() == 0) && !o_busy;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: acc_left=%0d rd_left=%0d busy=%b, want 0/0/0",
               name, acc_q.size(), rd_q.size(), o_busy);
      acc_q.delete();
      rd_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_cs_we_busy"}, {61'd0, o_cs, o_we, o_busy}, 64'd0);
    check({name, "_gnt_rvalid"}, {58'd0, o_gnt, o_rvalid}, 64'd0);
    check({name, "_rdata"}, {32'd0, o_rdata}, 64'd0);
    check({name, "_addr_data"}, {o_addr, o_data}, 64'd0);
  endtask

  initial begin : test
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write from requester 1: o_cs one cycle after sampling, busy drops after.
    issue(1, 1'b1, 32'h10, 32'hA5A5_0001);
    exp_acc(3'b010, 1'b1, 32'h10, 32'hA5A5_0001);
    wait_cs("wr_cs_latency", 2);
    check("wr_busy_in_access", {63'd0, o_busy}, 64'd1);
    @(negedge clk);
    check("wr_busy_fall", {63'd0, o_busy}, 64'd0);
    drain("wr");

    // Read from requester 0: ptr=2 so the search wraps to 0; rvalid in cycle k+4.
    issue(0, 1'b0, 32'h20, 32'h0);
    exp_acc(3'b001, 1'b0, 32'h20, 32'h0);
    exp_rd(3'b001, 32'h1234_5678);
    wait_rv("rd_rvalid_latency", 5);
    @(negedge clk);
    check("rd_busy_fall", {63'd0, o_busy}, 64'd0);
    drain("rd");

    // A write must not disturb o_rdata.
    issue(1, 1'b1, 32'h44, 32'h0BAD_F00D);
    exp_acc(3'b010, 1'b1, 32'h44, 32'h0BAD_F00D);
    drain("wr2");
    check("rdata_hold_after_write", {32'd0, o_rdata}, 64'h1234_5678);

    // Reset in RD_WAIT: outputs drop at once, no completion afterwards.
    issue(1, 1'b0, 32'h30, 32'h0);
    exp_acc(3'b010, 1'b0, 32'h30, 32'h0);
    wait_cs("rst_rd_cs_latency", 2);
    @(negedge clk);
    check("rst_busy_in_rd_wait", {63'd0, o_busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;

    // ptr restarted at 0: requester 1 must win before requester 2.
    issue(1, 1'b1, 32'h50, 32'h1111_0001);
    issue(2, 1'b1, 32'h54, 32'h2222_0002);
    exp_acc(3'b010, 1'b1, 32'h50, 32'h1111_0001);
    exp_acc(3'b100, 1'b1, 32'h54, 32'h2222_0002);
    drain("post_reset");

    // Contention between requesters 0 and 1, ptr=0.
    issue(0, 1'b1, 32'h60, 32'hC0);
    issue(0, 1'b1, 32'h64, 32'hC1);
    issue(1, 1'b1, 32'h68, 32'hD0);
    issue(1, 1'b1, 32'h6C, 32'hD1);
`ifdef REG_PORT_ARB_PRIO0_EN
    exp_acc(3'b001, 1'b1, 32'h60, 32'hC0);
    exp_acc(3'b001, 1'b1, 32'h64, 32'hC1);
    exp_acc(3'b010, 1'b1, 32'h68, 32'hD0);
    exp_acc(3'b010, 1'b1, 32'h6C, 32'hD1);
`else
    exp_acc(3'b001, 1'b1, 32'h60, 32'hC0);
    exp_acc(3'b010, 1'b1, 32'h68, 32'hD0);
    exp_acc(3'b001, 1'b1, 32'h64, 32'hC1);
    exp_acc(3'b010, 1'b1, 32'h6C, 32'hD1);
`endif
    drain("contention");

    // ptr=2: a lone requester-2 write brings it back to 0.
    issue(2, 1'b1, 32'h70, 32'h77);
    exp_acc(3'b100, 1'b1, 32'h70, 32'h77);
    drain("r2_single");

    // All three requesting with mixed reads/writes: wrap-around 0,1,2,0.
    issue(0, 1'b1, 32'h80, 32'hE0);
    issue(0, 1'b0, 32'h84, 32'h0);
    issue(1, 1'b0, 32'h88, 32'h0);
    issue(2, 1'b1, 32'h8C, 32'hE2);
`ifdef REG_PORT_ARB_PRIO0_EN
    exp_acc(3'b001, 1'b1, 32'h80, 32'hE0);
    exp_acc(3'b001, 1'b0, 32'h84, 32'h0);
    exp_acc(3'b010, 1'b0, 32'h88, 32'h0);
    exp_acc(3'b100, 1'b1, 32'h8C, 32'hE2);
    exp_rd(3'b001, 32'h1234_56DC);
    exp_rd(3'b010, 32'h1234_56E0);
`else
    exp_acc(3'b001, 1'b1, 32'h80, 32'hE0);
    exp_acc(3'b010, 1'b0, 32'h88, 32'h0);
    exp_acc(3'b100, 1'b1, 32'h8C, 32'hE2);
    exp_acc(3'b001, 1'b0, 32'h84, 32'h0);
    exp_rd(3'b010, 32'h1234_56E0);
    exp_rd(3'b001, 32'h1234_56DC);
`endif
    drain("wrap");
`ifdef REG_PORT_ARB_PRIO0_EN
    check("rdata_final", {32'd0, o_rdata}, 64'h1234_56E0);
`else
    check("rdata_final", {32'd0, o_rdata}, 64'h1234_56DC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "global timeout");
  end

endmodule
